// File: rtl/mac_accum.sv
// Multiply-accumulate of N_TERMS A*W products per frame into an 11-bit signed sum S.
// S/OUT_VALID valid the cycle after the last accepted beat; IN_READY drops while a result waits for OUT_READY.
module mac_accum #(
    parameter int N_TERMS = 8,
    parameter bit SAT_EN  = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        VDD,
    input  logic        CLR,
    input  logic [3:0]  A,
    input  logic [3:0]  W,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [10:0] S,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        SAT
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [4:0] LAST_CNT = 5'(N_TERMS);

    state_t             r_state;
    logic signed [10:0] r_acc;
    logic [4:0]         r_cnt;
    logic               r_sat;
    logic [10:0]        r_s;
    logic               r_sat_o;
    logic               r_out_vld;
    logic               r_in_rdy;

    logic signed [8:0]  w_a;
    logic signed [8:0]  w_w;
    logic signed [8:0]  w_prod;
    logic signed [10:0] w_base;
    logic signed [11:0] w_sum12;
    logic               w_ovf;
    logic [10:0]        w_next_acc;
    logic               w_next_sat;
    logic [4:0]         w_next_cnt;
    logic               w_first;
    logic               w_accept;

    assign w_a    = {5'b0, A};
    assign w_w    = {{5{W[3]}}, W};
    assign w_prod = w_a * w_w;

    // A beat taken in IDLE starts a fresh frame: accumulator and sat flag restart from zero.
    assign w_first    = (r_state == IDLE);
    assign w_base     = w_first ? 11'sd0 : r_acc;
    assign w_sum12    = {w_base[10], w_base} + {{3{w_prod[8]}}, w_prod};
    assign w_ovf      = w_sum12[11] ^ w_sum12[10];
    assign w_next_acc = (w_ovf && SAT_EN) ? (w_sum12[11] ? 11'h400 : 11'h3FF) : w_sum12[10:0];
    assign w_next_sat = (!w_first && r_sat) || w_ovf;
    assign w_next_cnt = (w_first ? 5'd0 : r_cnt) + 5'd1;
    assign w_accept   = IN_VALID && r_in_rdy;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_s       <= '0;
            r_sat_o   <= 1'b0;
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b0;
        end else if (CLR) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
        end else begin
            case (r_state)
                IDLE, ACC: begin
                    r_in_rdy <= 1'b1;
                    if (w_accept) begin
                        r_acc <= w_next_acc;
                        r_sat <= w_next_sat;
                        r_cnt <= w_next_cnt;
                        if (w_next_cnt == LAST_CNT) begin
                            r_state   <= DONE;
                            r_s       <= w_next_acc;
                            r_sat_o   <= w_next_sat;
                            r_out_vld <= 1'b1;
                            r_in_rdy  <= 1'b0;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_out_vld <= 1'b0;
                        r_in_rdy  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_in_rdy <= 1'b0;
                end
            endcase
        end
    end

    // Outputs swing between ground and the supply rail.
    assign S         = r_s & {11{VDD}};
    assign SAT       = r_sat_o & VDD;
    assign OUT_VALID = r_out_vld & VDD;
    assign IN_READY  = r_in_rdy & VDD;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: one 8-term saturating instance, two 16-term instances (clamp and wrap).
module tb_mac_accum;

    logic        CLK;
    logic        RSTB;
    logic        VDD;
    logic        CLR;
    logic [3:0]  A;
    logic [3:0]  W;
    logic        iv8;
    logic        iv16;
    logic        OUT_READY;

    logic        ir8, ov8, sat8;
    logic [10:0] s8;
    logic        ir16, ov16, sat16;
    logic [10:0] s16;
    logic        ir16w, ov16w, sat16w;
    logic [10:0] s16w;

    int checks = 0;
    int errors = 0;

    mac_accum #(.N_TERMS(8), .SAT_EN(1'b1)) dut8 (
        .CLK(CLK), .RSTB(RSTB), .VDD(VDD), .CLR(CLR), .A(A), .W(W),
        .IN_VALID(iv8), .IN_READY(ir8), .S(s8), .OUT_VALID(ov8),
        .OUT_READY(OUT_READY), .SAT(sat8)
    );

    mac_accum #(.N_TERMS(16), .SAT_EN(1'b1)) dut16 (
        .CLK(CLK), .RSTB(RSTB), .VDD(VDD), .CLR(CLR), .A(A), .W(W),
        .IN_VALID(iv16), .IN_READY(ir16), .S(s16), .OUT_VALID(ov16),
        .OUT_READY(OUT_READY), .SAT(sat16)
    );

    mac_accum #(.N_TERMS(16), .SAT_EN(1'b0)) dut16w (
        .CLK(CLK), .RSTB(RSTB), .VDD(VDD), .CLR(CLR), .A(A), .W(W),
        .IN_VALID(iv16), .IN_READY(ir16w), .S(s16w), .OUT_VALID(ov16w),
        .OUT_READY(OUT_READY), .SAT(sat16w)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] relu(input logic [10:0] s);
        return s[10] ? 8'd0 : s[9:2];
    endfunction

    task automatic set_iv(input int sel, input logic v);
        if (sel == 0) iv8 = v;
        else          iv16 = v;
    endtask

    // n beats of (a, w); with gap set, a bubble cycle precedes every beat after the first.
    task automatic beats(input int sel, input int a, input int w, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                set_iv(sel, 1'b0);
                @(posedge CLK); #1;
            end
            A = a[3:0];
            W = w[3:0];
            set_iv(sel, 1'b1);
            @(posedge CLK); #1;
        end
        set_iv(sel, 1'b0);
    endtask

    task automatic handoff();
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
    endtask

    initial begin
        VDD = 1'b1; RSTB = 1'b0; CLR = 1'b0; A = '0; W = '0;
        iv8 = 1'b0; iv16 = 1'b0; OUT_READY = 1'b0;
        #1;
        chk("reset_s",   32'(s8),   32'h0);
        chk("reset_ov",  32'(ov8),  32'h0);
        chk("reset_ir",  32'(ir8),  32'h0);
        chk("reset_sat", 32'(sat8), 32'h0);
        @(posedge CLK); #3;
        RSTB = 1'b1;
        #1;
        chk("ir_before_edge", 32'(ir8), 32'h0);
        @(posedge CLK); #1;
        chk("ir_after_release", 32'(ir8), 32'h1);

        // positive frame: 8 x (15*7) = 840
        beats(0, 15, 7, 7, 1'b0);
        chk("pos_ov_early", 32'(ov8), 32'h0);
        beats(0, 15, 7, 1, 1'b0);
        chk("pos_ov",   32'(ov8),       32'h1);
        chk("pos_s",    32'(s8),        32'h348);
        chk("pos_sat",  32'(sat8),      32'h0);
        chk("pos_relu", 32'(relu(s8)),  32'd210);
        chk("pos_ir",   32'(ir8),       32'h0);
        handoff();
        chk("pos_hand_ov", 32'(ov8), 32'h0);
        chk("pos_hand_ir", 32'(ir8), 32'h1);
        chk("pos_hand_s",  32'(s8),  32'h348);

        // negative frame: 8 x (15*-8) = -960
        beats(0, 15, -8, 8, 1'b0);
        chk("neg_ov",   32'(ov8),      32'h1);
        chk("neg_s",    32'(s8),       32'h440);
        chk("neg_sign", 32'(s8[10]),   32'h1);
        chk("neg_sat",  32'(sat8),     32'h0);
        chk("neg_relu", 32'(relu(s8)), 32'd0);
        handoff();

        // bubbles between every beat
        beats(0, 15, 7, 8, 1'b1);
        chk("bub_ov", 32'(ov8), 32'h1);
        chk("bub_s",  32'(s8),  32'h348);

        // backpressure: beats offered while DONE must be ignored
        A = 4'd1; W = 4'd1; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("bp_ir", 32'(ir8), 32'h0);
            chk("bp_ov", 32'(ov8), 32'h1);
            chk("bp_s",  32'(s8),  32'h348);
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0; iv8 = 1'b0;
        chk("bp_hand_ov", 32'(ov8), 32'h0);
        chk("bp_hand_ir", 32'(ir8), 32'h1);
        // 8 x (2*3) = 48 proves no beat leaked in during DONE or the handoff edge
        beats(0, 2, 3, 8, 1'b0);
        chk("bp_next_ov", 32'(ov8), 32'h1);
        chk("bp_next_s",  32'(s8),  32'd48);
        handoff();

        // abort after 3 beats, with a beat offered alongside CLR
        beats(0, 15, 7, 3, 1'b0);
        CLR = 1'b1; iv8 = 1'b1; A = 4'd15; W = 4'd7;
        @(posedge CLK); #1;
        CLR = 1'b0; iv8 = 1'b0;
        chk("clr_ov", 32'(ov8), 32'h0);
        chk("clr_s",  32'(s8),  32'd48);
        beats(0, 1, 1, 7, 1'b0);
        chk("clr_ov_early", 32'(ov8), 32'h0);
        beats(0, 1, 1, 1, 1'b0);
        chk("clr_next_ov", 32'(ov8), 32'h1);
        chk("clr_next_s",  32'(s8),  32'd8);
        handoff();

        // 16 x (15*-8) = -1920: clamps to -1024, wraps to 128
        beats(1, 15, -8, 16, 1'b0);
        chk("satn_ov",    32'(ov16),   32'h1);
        chk("satn_s",     32'(s16),    32'h400);
        chk("satn_sat",   32'(sat16),  32'h1);
        chk("wrapn_ov",   32'(ov16w),  32'h1);
        chk("wrapn_s",    32'(s16w),   32'h080);
        chk("wrapn_sat",  32'(sat16w), 32'h1);
        handoff();

        // 16 x (15*7) = 1680: clamps to 1023, wraps to 0x690
        beats(1, 15, 7, 16, 1'b0);
        chk("satp_s",    32'(s16),    32'h3FF);
        chk("satp_sat",  32'(sat16),  32'h1);
        chk("wrapp_s",   32'(s16w),   32'h690);
        chk("wrapp_sat", 32'(sat16w), 32'h1);
        handoff();

        // in-range frame clears the sticky flag: 16 x (1*-1) = -16
        beats(1, 1, -1, 16, 1'b0);
        chk("nosat_s",     32'(s16),    32'h7F0);
        chk("nosat_sat",   32'(sat16),  32'h0);
        chk("nowrap_s",    32'(s16w),   32'h7F0);
        chk("nowrap_sat",  32'(sat16w), 32'h0);
        handoff();

        // asynchronous reset mid-frame
        beats(0, 15, 7, 5, 1'b0);
        #2;
        RSTB = 1'b0;
        #1;
        chk("rst_mid_s",  32'(s8),  32'h0);
        chk("rst_mid_ov", 32'(ov8), 32'h0);
        chk("rst_mid_ir", 32'(ir8), 32'h0);
        @(posedge CLK); #3;
        RSTB = 1'b1;
        @(posedge CLK); #1;
        chk("rst_rel_ir", 32'(ir8), 32'h1);
        beats(0, 15, 7, 8, 1'b0);
        chk("rst_frame_ov",  32'(ov8),  32'h1);
        chk("rst_frame_s",   32'(s8),   32'h348);
        chk("rst_frame_sat", 32'(sat8), 32'h0);
        handoff();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
